// File: rtl/vx_mem_arbiter.sv
// vx_mem_arbiter
// Two-to-one arbiter sharing one local memory port between the host program
// loader (port 0) and the Vortex memory interface (port 1). Requests and
// responses pass combinationally. A small in-order ID FIFO records which port
// issued each read, so in-order memory responses can be steered back.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   sN_req_*  / sN_req_ready         requester N request channel (rw=1 write)
//   sN_rsp_*  / sN_rsp_ready         read response channel to requester N
//   m_req_*   / m_req_ready          request channel to memory
//   m_rsp_*   / m_rsp_ready          in-order read responses from memory
//   busy                             request pending or reads outstanding
//   rsp_err                          sticky: response seen with nothing outstanding
//
// Handshake rule (all channels): a transfer happens on a rising clk edge where
// valid and ready are both 1. Once valid is raised the payload stays stable
// until that transfer; ready may depend combinationally on valid.
module vx_mem_arbiter #(
    parameter int ADDR_W   = 26,
    parameter int DATA_W   = 512,
    parameter int BYTEEN_W = DATA_W / 8,
    parameter int TAG_W    = 8,
    parameter int OUTST    = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                s0_req_valid,
    input  logic                s0_req_rw,
    input  logic [BYTEEN_W-1:0] s0_req_byteen,
    input  logic [ADDR_W-1:0]   s0_req_addr,
    input  logic [DATA_W-1:0]   s0_req_data,
    input  logic [TAG_W-1:0]    s0_req_tag,
    output logic                s0_req_ready,
    output logic                s0_rsp_valid,
    output logic [DATA_W-1:0]   s0_rsp_data,
    output logic [TAG_W-1:0]    s0_rsp_tag,
    input  logic                s0_rsp_ready,

    input  logic                s1_req_valid,
    input  logic                s1_req_rw,
    input  logic [BYTEEN_W-1:0] s1_req_byteen,
    input  logic [ADDR_W-1:0]   s1_req_addr,
    input  logic [DATA_W-1:0]   s1_req_data,
    input  logic [TAG_W-1:0]    s1_req_tag,
    output logic                s1_req_ready,
    output logic                s1_rsp_valid,
    output logic [DATA_W-1:0]   s1_rsp_data,
    output logic [TAG_W-1:0]    s1_rsp_tag,
    input  logic                s1_rsp_ready,

    output logic                m_req_valid,
    output logic                m_req_rw,
    output logic [BYTEEN_W-1:0] m_req_byteen,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_data,
    output logic [TAG_W-1:0]    m_req_tag,
    input  logic                m_req_ready,

    input  logic                m_rsp_valid,
    input  logic [DATA_W-1:0]   m_rsp_data,
    input  logic [TAG_W-1:0]    m_rsp_tag,
    output logic                m_rsp_ready,

    output logic                busy,
    output logic                rsp_err
);

    localparam int CNT_W = $clog2(OUTST + 1);
    localparam int PTR_W = $clog2(OUTST);

    logic               rr_ptr;
    logic               locked;
    logic               lock_id;
    logic [OUTST-1:0]   id_fifo;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               rsp_err_q;

    logic elig0, elig1;
    logic grant_any, grant_id, grant_elig;
    logic req_fire, push, pop;
    logic fifo_empty, head_id;

    // Reads are blocked once the ID FIFO is full; writes never need a slot.
    // Registered cnt is used, so a pop in this cycle cannot unblock a read.
    assign elig0 = s0_req_valid & (s0_req_rw | (cnt < CNT_W'(OUTST)));
    assign elig1 = s1_req_valid & (s1_req_rw | (cnt < CNT_W'(OUTST)));

    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (locked) begin
            // Stalled grant is held so m_req_* stays stable until accepted.
            grant_any = 1'b1;
            grant_id  = lock_id;
        end else if (elig0 && elig1) begin
            grant_any = 1'b1;
            grant_id  = rr_ptr;
        end else if (elig0) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
        end else if (elig1) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign grant_elig   = grant_id ? elig1 : elig0;
    assign m_req_valid  = reset_n & grant_any & grant_elig;
    assign m_req_rw     = grant_id ? s1_req_rw     : s0_req_rw;
    assign m_req_byteen = grant_id ? s1_req_byteen : s0_req_byteen;
    assign m_req_addr   = grant_id ? s1_req_addr   : s0_req_addr;
    assign m_req_data   = grant_id ? s1_req_data   : s0_req_data;
    assign m_req_tag    = grant_id ? s1_req_tag    : s0_req_tag;

    assign req_fire     = m_req_valid & m_req_ready;
    assign s0_req_ready = req_fire & ~grant_id;
    assign s1_req_ready = req_fire &  grant_id;
    assign push         = req_fire & ~m_req_rw;

    // Response steering by the ID at the FIFO head. With nothing outstanding
    // the memory side is drained (ready=1) and the stray beat flagged.
    assign fifo_empty  = (cnt == '0);
    assign head_id     = id_fifo[rd_ptr];
    assign s0_rsp_valid = reset_n & ~fifo_empty & m_rsp_valid & ~head_id;
    assign s1_rsp_valid = reset_n & ~fifo_empty & m_rsp_valid &  head_id;
    assign s0_rsp_data  = m_rsp_data;
    assign s0_rsp_tag   = m_rsp_tag;
    assign s1_rsp_data  = m_rsp_data;
    assign s1_rsp_tag   = m_rsp_tag;
    assign m_rsp_ready  = reset_n & (fifo_empty | (head_id ? s1_rsp_ready : s0_rsp_ready));
    assign pop          = m_rsp_valid & m_rsp_ready & ~fifo_empty;

    assign busy    = reset_n & (m_req_valid | ~fifo_empty);
    assign rsp_err = rsp_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= 1'b0;
            locked    <= 1'b0;
            lock_id   <= 1'b0;
            id_fifo   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (req_fire) begin
                locked <= 1'b0;
                rr_ptr <= ~grant_id;
            end else if (m_req_valid) begin
                locked  <= 1'b1;
                lock_id <= grant_id;
            end

            if (push) begin
                id_fifo[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase

            if (m_rsp_valid && fifo_empty) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vx_mem_arbiter.sv
module tb_vx_mem_arbiter;

  localparam int ADDR_W   = 26;
  localparam int DATA_W   = 32;
  localparam int BYTEEN_W = DATA_W / 8;
  localparam int TAG_W    = 8;
  localparam int OUTST    = 4;
  // expected request word: {one-hot port ready, rw, addr, tag, data}
  localparam int REQ_W    = 2 + 1 + ADDR_W + TAG_W + DATA_W;
  localparam int RSP_W    = DATA_W + TAG_W;

  logic                clk;
  logic                reset_n;
  logic                s0_req_valid, s0_req_rw, s0_req_ready;
  logic [BYTEEN_W-1:0] s0_req_byteen;
  logic [ADDR_W-1:0]   s0_req_addr;
  logic [DATA_W-1:0]   s0_req_data;
  logic [TAG_W-1:0]    s0_req_tag;
  logic                s0_rsp_valid, s0_rsp_ready;
  logic [DATA_W-1:0]   s0_rsp_data;
  logic [TAG_W-1:0]    s0_rsp_tag;
  logic                s1_req_valid, s1_req_rw, s1_req_ready;
  logic [BYTEEN_W-1:0] s1_req_byteen;
  logic [ADDR_W-1:0]   s1_req_addr;
  logic [DATA_W-1:0]   s1_req_data;
  logic [TAG_W-1:0]    s1_req_tag;
  logic                s1_rsp_valid, s1_rsp_ready;
  logic [DATA_W-1:0]   s1_rsp_data;
  logic [TAG_W-1:0]    s1_rsp_tag;
  logic                m_req_valid, m_req_rw, m_req_ready;
  logic [BYTEEN_W-1:0] m_req_byteen;
  logic [ADDR_W-1:0]   m_req_addr;
  logic [DATA_W-1:0]   m_req_data;
  logic [TAG_W-1:0]    m_req_tag;
  logic                m_rsp_valid, m_rsp_ready;
  logic [DATA_W-1:0]   m_rsp_data;
  logic [TAG_W-1:0]    m_rsp_tag;
  logic                busy, rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [REQ_W-1:0] exp_req_q[$];
  logic [RSP_W-1:0] exp_rsp0_q[$];
  logic [RSP_W-1:0] exp_rsp1_q[$];

  vx_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTEEN_W(BYTEEN_W), .TAG_W(TAG_W), .OUTST(OUTST)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_req_valid(s0_req_valid), .s0_req_rw(s0_req_rw), .s0_req_byteen(s0_req_byteen),
    .s0_req_addr(s0_req_addr), .s0_req_data(s0_req_data), .s0_req_tag(s0_req_tag),
    .s0_req_ready(s0_req_ready), .s0_rsp_valid(s0_rsp_valid), .s0_rsp_data(s0_rsp_data),
    .s0_rsp_tag(s0_rsp_tag), .s0_rsp_ready(s0_rsp_ready),
    .s1_req_valid(s1_req_valid), .s1_req_rw(s1_req_rw), .s1_req_byteen(s1_req_byteen),
    .s1_req_addr(s1_req_addr), .s1_req_data(s1_req_data), .s1_req_tag(s1_req_tag),
    .s1_req_ready(s1_req_ready), .s1_rsp_valid(s1_rsp_valid), .s1_rsp_data(s1_rsp_data),
    .s1_rsp_tag(s1_rsp_tag), .s1_rsp_ready(s1_rsp_ready),
    .m_req_valid(m_req_valid), .m_req_rw(m_req_rw), .m_req_byteen(m_req_byteen),
    .m_req_addr(m_req_addr), .m_req_data(m_req_data), .m_req_tag(m_req_tag),
    .m_req_ready(m_req_ready),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_tag(m_rsp_tag),
    .m_rsp_ready(m_rsp_ready),
    .busy(busy), .rsp_err(rsp_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_s0(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    s0_req_valid = v; s0_req_rw = rw; s0_req_addr = a; s0_req_tag = t; s0_req_data = d;
  endtask

  task automatic drive_s1(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    s1_req_valid = v; s1_req_rw = rw; s1_req_addr = a; s1_req_tag = t; s1_req_data = d;
  endtask

  // port: 0 or 1 -> one-hot of {s1_req_ready, s0_req_ready}
  task automatic exp_req(input int port, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    exp_req_q.push_back({oh, rw, a, t, d});
  endtask

  task automatic drive_mrsp(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    m_rsp_valid = v; m_rsp_data = d; m_rsp_tag = t;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [REQ_W-1:0] act_req, e_req;
    logic [RSP_W-1:0] e_rsp;
    if (reset_n && m_req_valid && m_req_ready) begin
      act_req = {s1_req_ready, s0_req_ready, m_req_rw, m_req_addr, m_req_tag, m_req_data};
      checks++;
      if (exp_req_q.size() == 0) begin
        failures++;
        $display("FAIL req_unexpected: got %0h expected none", act_req);
      end else begin
        e_req = exp_req_q.pop_front();
        if (act_req !== e_req) begin
          failures++;
          $display("FAIL req_fire: got %0h expected %0h", act_req, e_req);
        end
      end
    end
    if (s0_rsp_valid && s0_rsp_ready) begin
      checks++;
      if (exp_rsp0_q.size() == 0) begin
        failures++;
        $display("FAIL rsp0_unexpected: got %0h expected none", {s0_rsp_data, s0_rsp_tag});
      end else begin
        e_rsp = exp_rsp0_q.pop_front();
        if ({s0_rsp_data, s0_rsp_tag} !== e_rsp) begin
          failures++;
          $display("FAIL rsp0: got %0h expected %0h", {s0_rsp_data, s0_rsp_tag}, e_rsp);
        end
      end
    end
    if (s1_rsp_valid && s1_rsp_ready) begin
      checks++;
      if (exp_rsp1_q.size() == 0) begin
        failures++;
        $display("FAIL rsp1_unexpected: got %0h expected none", {s1_rsp_data, s1_rsp_tag});
      end else begin
        e_rsp = exp_rsp1_q.pop_front();
        if ({s1_rsp_data, s1_rsp_tag} !== e_rsp) begin
          failures++;
          $display("FAIL rsp1: got %0h expected %0h", {s1_rsp_data, s1_rsp_tag}, e_rsp);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0;
    s0_req_byteen = '1;
    s1_req_byteen = '1;
    s0_rsp_ready = 1'b1;
    s1_rsp_ready = 1'b1;
    // activity on inputs during reset must not leak to outputs
    drive_s0(1'b1, 1'b1, 26'h10, 8'h10, 32'h1000);
    drive_s1(1'b0, 1'b0, '0, '0, '0);
    m_req_ready = 1'b1;
    drive_mrsp(1'b1, 32'h5, 8'h5);
    repeat (2) sample();
    check("rst_m_req_valid", m_req_valid, 0);
    check("rst_s0_req_ready", s0_req_ready, 0);
    check("rst_m_rsp_ready", m_rsp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_err", rsp_err, 0);
    drive_s0(1'b0, 1'b0, '0, '0, '0);
    drive_mrsp(1'b0, '0, '0);

    // release; empty FIFO drains responses
    step();
    reset_n = 1'b1;
    sample();
    check("idle_m_rsp_ready", m_rsp_ready, 1);
    check("idle_busy", busy, 0);

    // both ports write continuously: grants 0,1,0,1
    exp_req(0, 1'b1, 26'h10, 8'h10, 32'h1000);
    exp_req(1, 1'b1, 26'h20, 8'h20, 32'h2000);
    exp_req(0, 1'b1, 26'h10, 8'h10, 32'h1000);
    exp_req(1, 1'b1, 26'h20, 8'h20, 32'h2000);
    step();
    drive_s0(1'b1, 1'b1, 26'h10, 8'h10, 32'h1000);
    drive_s1(1'b1, 1'b1, 26'h20, 8'h20, 32'h2000);
    repeat (4) step();
    drive_s0(1'b0, 1'b0, '0, '0, '0);
    drive_s1(1'b0, 1'b0, '0, '0, '0);

    // lock: port 1 read stalled 3 cycles, port 0 arrives at cycle 1
    m_req_ready = 1'b0;
    drive_s1(1'b1, 1'b0, 26'h30, 8'h77, 32'h0);
    exp_req(1, 1'b0, 26'h30, 8'h77, 32'h0);
    sample();
    check("lock_c0_valid", m_req_valid, 1);
    check("lock_c0_s1_ready", s1_req_ready, 0);
    step();
    drive_s0(1'b1, 1'b1, 26'h40, 8'h44, 32'h4000);
    exp_req(0, 1'b1, 26'h40, 8'h44, 32'h4000);
    sample();
    check("lock_c1_addr", m_req_addr, 26'h30);
    check("lock_c1_s0_ready", s0_req_ready, 0);
    step();
    sample();
    check("lock_c2_addr", m_req_addr, 26'h30);
    step();
    m_req_ready = 1'b1;
    sample();
    check("lock_c3_s0_ready", s0_req_ready, 0);
    step();
    drive_s1(1'b0, 1'b0, '0, '0, '0);
    sample();
    step();
    drive_s0(1'b0, 1'b0, '0, '0, '0);
    drive_mrsp(1'b1, 32'h1234, 8'h77);
    exp_rsp1_q.push_back({32'h1234, 8'h77});
    sample();
    check("lock_rsp_s0_valid", s0_rsp_valid, 0);
    step();
    drive_mrsp(1'b0, '0, '0);
    sample();
    check("lock_done_busy", busy, 0);

    // outstanding limit: four reads fill the FIFO, fifth blocks
    step();
    drive_s1(1'b1, 1'b0, 26'h50, 8'h51, 32'h0);
    for (int i = 0; i < 4; i++) exp_req(1, 1'b0, 26'h50, 8'h51, 32'h0);
    repeat (4) step();
    sample();
    check("full_m_req_valid", m_req_valid, 0);
    check("full_s1_ready", s1_req_ready, 0);
    check("full_busy", busy, 1);
    step();
    drive_s0(1'b1, 1'b1, 26'h60, 8'h66, 32'h6000);
    exp_req(0, 1'b1, 26'h60, 8'h66, 32'h6000);
    sample();
    check("full_s0_write_ready", s0_req_ready, 1);
    step();
    drive_s0(1'b0, 1'b0, '0, '0, '0);
    drive_mrsp(1'b1, 32'hA0, 8'h51);
    exp_rsp1_q.push_back({32'hA0, 8'h51});
    sample();
    check("full_pop_no_push", m_req_valid, 0);
    step();
    drive_mrsp(1'b0, '0, '0);
    exp_req(1, 1'b0, 26'h50, 8'h51, 32'h0);
    sample();
    check("full_fifth_fires", s1_req_ready, 1);
    step();
    drive_s1(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      drive_mrsp(1'b1, 32'hB0 + 32'(i), 8'h51);
      exp_rsp1_q.push_back({32'hB0 + 32'(i), 8'h51});
      step();
    end
    drive_mrsp(1'b0, '0, '0);
    sample();
    check("drain_busy", busy, 0);

    // response steering: reads 0,1,0 then responses A,B,C with a stall
    step();
    drive_s0(1'b1, 1'b0, 26'h70, 8'h03, 32'h0);
    exp_req(0, 1'b0, 26'h70, 8'h03, 32'h0);
    step();
    drive_s0(1'b0, 1'b0, '0, '0, '0);
    drive_s1(1'b1, 1'b0, 26'h71, 8'h07, 32'h0);
    exp_req(1, 1'b0, 26'h71, 8'h07, 32'h0);
    step();
    drive_s1(1'b0, 1'b0, '0, '0, '0);
    drive_s0(1'b1, 1'b0, 26'h72, 8'h09, 32'h0);
    exp_req(0, 1'b0, 26'h72, 8'h09, 32'h0);
    step();
    drive_s0(1'b0, 1'b0, '0, '0, '0);
    drive_mrsp(1'b1, 32'hA, 8'h03);
    exp_rsp0_q.push_back({32'hA, 8'h03});
    sample();
    check("steer_a_s1_valid", s1_rsp_valid, 0);
    step();
    drive_mrsp(1'b1, 32'hB, 8'h07);
    s1_rsp_ready = 1'b0;
    sample();
    check("steer_stall_m_rsp_ready", m_rsp_ready, 0);
    check("steer_stall_s1_valid", s1_rsp_valid, 1);
    check("steer_stall_s0_valid", s0_rsp_valid, 0);
    step();
    s1_rsp_ready = 1'b1;
    exp_rsp1_q.push_back({32'hB, 8'h07});
    sample();
    step();
    drive_mrsp(1'b1, 32'hC, 8'h09);
    exp_rsp0_q.push_back({32'hC, 8'h09});
    sample();
    check("steer_c_s0_valid", s0_rsp_valid, 1);
    step();
    drive_mrsp(1'b0, '0, '0);
    sample();
    check("steer_done_busy", busy, 0);

    // stray response with nothing outstanding
    step();
    drive_mrsp(1'b1, 32'hDEAD, 8'hEE);
    sample();
    check("stray_s0_valid", s0_rsp_valid, 0);
    check("stray_s1_valid", s1_rsp_valid, 0);
    check("stray_m_rsp_ready", m_rsp_ready, 1);
    check("stray_err_before_edge", rsp_err, 0);
    step();
    drive_mrsp(1'b0, '0, '0);
    sample();
    check("stray_err_set", rsp_err, 1);
    repeat (3) step();
    sample();
    check("stray_err_sticky", rsp_err, 1);

    // reset mid-lock with two reads outstanding
    step();
    drive_s0(1'b1, 1'b0, 26'h80, 8'h81, 32'h0);
    exp_req(0, 1'b0, 26'h80, 8'h81, 32'h0);
    exp_req(0, 1'b0, 26'h80, 8'h81, 32'h0);
    repeat (2) step();
    drive_s0(1'b0, 1'b0, '0, '0, '0);
    drive_s1(1'b1, 1'b0, 26'h90, 8'h91, 32'h0);
    m_req_ready = 1'b0;
    sample();
    check("rstlock_m_req_valid", m_req_valid, 1);
    check("rstlock_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstlock_async_m_req_valid", m_req_valid, 0);
    check("rstlock_async_s1_ready", s1_req_ready, 0);
    check("rstlock_async_busy", busy, 0);
    check("rstlock_async_m_rsp_ready", m_rsp_ready, 0);
    check("rstlock_async_err_clear", rsp_err, 0);
    drive_s1(1'b0, 1'b0, '0, '0, '0);
    m_req_ready = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    sample();
    check("rstlock_after_busy", busy, 0);
    check("rstlock_after_m_rsp_ready", m_rsp_ready, 1);
    step();
    drive_mrsp(1'b1, 32'h99, 8'h81);
    sample();
    check("rstlock_stray_s0_valid", s0_rsp_valid, 0);
    step();
    drive_mrsp(1'b0, '0, '0);
    sample();
    check("rstlock_stray_err", rsp_err, 1);

    // final report
    step();
    check("left_exp_req", 64'(exp_req_q.size()), 0);
    check("left_exp_rsp0", 64'(exp_rsp0_q.size()), 0);
    check("left_exp_rsp1", 64'(exp_rsp1_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
